wash_job_scheduler: RTL and testbench

//   Queues wash-program requests and dispatches them one at a time to the FSMW washer core.
//   It gates each dispatch on door and soap conditions and issues a 1-cycle start pulse.
//   It supervises the run with a watchdog and counts completed jobs.

---
 rtl/wash_job_scheduler_if.sv | 22 ++
 rtl/wash_job_scheduler.sv | 159 +++++++++++++++
 tb/tb_wash_job_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wash_job_scheduler_if.sv
// Request channel into the wash job scheduler.
// master = request source (panel/remote), slave = scheduler.
interface wash_job_scheduler_if;
  logic       req_valid;
  logic [2:0] req_prog;
  logic       req_ready;
  logic       req_reject;

  modport master (
    output req_valid,
    output req_prog,
    input  req_ready,
    input  req_reject
  );

  modport slave (
    input  req_valid,
    input  req_prog,
    output req_ready,
    output req_reject
  );
endinterface

// File: rtl/wash_job_scheduler.sv
// Wash job scheduler: queues program requests and dispatches them to FSMW.
// Ports: clk, rst (sync, high), power, req (request if), doorclosed, soap,
// washer_done in; washer_program, washer_start, busy, hold_reason,
// queue_count, jobs_done, fault out.
module wash_job_scheduler #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     power,
  wash_job_scheduler_if.slave      req,
  input  logic                     doorclosed,
  input  logic                     soap,
  input  logic                     washer_done,
  output logic [2:0]               washer_program,
  output logic                     washer_start,
  output logic                     busy,
  output logic [1:0]               hold_reason,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [7:0]               jobs_done,
  output logic                     fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, START, RUN, DONE, FLT
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [WW-1:0] wd;
  logic          fault_q;
  logic          ready;
  logic          push, pop;
  logic [2:0]    head;
  logic          need_soap;

  assign head      = mem[rptr];
  assign need_soap = (head <= 3'd1) && !soap;

  assign ready = power &&
                 (count != (AW+1)'(DEPTH)) &&
                 !fault_q;
  assign push  = req.req_valid && ready &&
                 (req.req_prog <= 3'd3);
  assign pop   = (state_q == START) && power;

  assign req.req_ready = ready;
  assign queue_count   = count;
  assign fault         = fault_q;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= req.req_prog;
  end

  always_ff @(posedge clk) begin
    if (rst || !power) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) req.req_reject <= 1'b0;
    else     req.req_reject <= req.req_valid && ready &&
                               (req.req_prog > 3'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (count != '0 && !fault_q) state_d = CHECK;
      CHECK:
        if (doorclosed && !need_soap) state_d = START;
      START:
        state_d = RUN;
      RUN:
        if (washer_done)   state_d = DONE;
        else if (wd == '0) state_d = FLT;
      DONE:
        state_d = IDLE;
      FLT:
        state_d = FLT;
      default:
        state_d = IDLE;
    endcase
    // Losing mains drops back to IDLE from anywhere, even FLT;
    // fault_q stays set so IDLE still refuses to dispatch.
    if (!power) state_d = IDLE;
  end

  always_comb begin
    busy         = 1'b0;
    washer_start = 1'b0;
    hold_reason  = 2'b00;
    unique case (state_q)
      START: begin
        busy         = 1'b1;
        washer_start = power;
      end
      RUN:
        busy = 1'b1;
      CHECK:
        if (power) begin
          unique case (1'b1)
            !doorclosed:             hold_reason = 2'b01;
            doorclosed && need_soap: hold_reason = 2'b10;
            default:                 hold_reason = 2'b00;
          endcase
        end
      default: ;
    endcase
  end

  // wd counts remaining RUN cycles; loading TIMEOUT_CYC-1 makes the
  // TIMEOUT_CYC-th RUN cycle the one that sees zero and expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd             <= '0;
      fault_q        <= 1'b0;
      jobs_done      <= '0;
      washer_program <= '0;
    end else begin
      if (state_q == START)
        wd <= WW'(TIMEOUT_CYC - 1);
      else if (state_q == RUN && wd != '0)
        wd <= wd - WW'(1);
      if (state_d == FLT)
        fault_q <= 1'b1;
      if (state_q == RUN && state_d == DONE &&
          jobs_done != 8'hff)
        jobs_done <= jobs_done + 8'd1;
      if (state_q == CHECK && state_d == START)
        washer_program <= head;
    end
  end

endmodule

// File: tb/tb_wash_job_scheduler.sv
// Directed bench for wash_job_scheduler.
// Two instances: default watchdog and a short 100-cycle watchdog.
module tb_wash_job_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance
  logic       rst, power, door, soap, wdone;
  logic [2:0] wprog;
  logic       wstart, busy, fault;
  logic [1:0] hold;
  logic [2:0] qcnt;
  logic [7:0] jobs;
  wash_job_scheduler_if ifc ();

  wash_job_scheduler #(.DEPTH(4), .TIMEOUT_CYC(1023)) dut (
    .clk(clk), .rst(rst), .power(power), .req(ifc),
    .doorclosed(door), .soap(soap), .washer_done(wdone),
    .washer_program(wprog), .washer_start(wstart), .busy(busy),
    .hold_reason(hold), .queue_count(qcnt), .jobs_done(jobs),
    .fault(fault)
  );

  // short-watchdog instance
  logic       rst_t, power_t, door_t, soap_t, wdone_t;
  logic [2:0] wprog_t;
  logic       wstart_t, busy_t, fault_t;
  logic [1:0] hold_t;
  logic [2:0] qcnt_t;
  logic [7:0] jobs_t;
  wash_job_scheduler_if ifc_t ();

  wash_job_scheduler #(.DEPTH(4), .TIMEOUT_CYC(100)) dut_t (
    .clk(clk), .rst(rst_t), .power(power_t), .req(ifc_t),
    .doorclosed(door_t), .soap(soap_t), .washer_done(wdone_t),
    .washer_program(wprog_t), .washer_start(wstart_t),
    .busy(busy_t), .hold_reason(hold_t), .queue_count(qcnt_t),
    .jobs_done(jobs_t), .fault(fault_t)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] p);
    ifc.req_valid = 1'b1;
    ifc.req_prog  = p;
    step();
    ifc.req_valid = 1'b0;
  endtask

  task automatic dispatch(input string tag, input int exp);
    int n = 0;
    while (!wstart && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, int'(wstart), 1);
    chk({tag, "_prog"}, int'(wprog), exp);
    step();
    chk({tag, "_pulse1"}, int'(wstart), 0);
    step();
    wdone = 1'b1;
    step();
    wdone = 1'b0;
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; power = 1'b1; door = 1'b0; soap = 1'b0; wdone = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_prog = 3'd0;
    rst_t = 1'b1; power_t = 1'b1; door_t = 1'b1; soap_t = 1'b1;
    wdone_t = 1'b0; ifc_t.req_valid = 1'b0; ifc_t.req_prog = 3'd0;

    // 1: reset state
    step(); step();
    chk("rst_ready", int'(ifc.req_ready), 1);
    chk("rst_start", int'(wstart), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qcnt", int'(qcnt), 0);
    chk("rst_jobs", int'(jobs), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_reject", int'(ifc.req_reject), 0);
    rst = 1'b0;

    // 2: single job, start two edges after acceptance
    door = 1'b1; soap = 1'b1;
    push(3'd0);
    chk("t2_qcnt1", int'(qcnt), 1);
    step();
    chk("t2_nostart_e1", int'(wstart), 0);
    step();
    chk("t2_start_e2", int'(wstart), 1);
    chk("t2_prog", int'(wprog), 0);
    chk("t2_busy", int'(busy), 1);
    step();
    chk("t2_pulse1", int'(wstart), 0);
    chk("t2_run_busy", int'(busy), 1);
    chk("t2_popped", int'(qcnt), 0);
    repeat (198) step();
    wdone = 1'b1;
    step();
    wdone = 1'b0;
    chk("t2_jobs", int'(jobs), 1);
    step();
    chk("t2_busy0", int'(busy), 0);
    chk("t2_qcnt0", int'(qcnt), 0);

    // 3: door open, fill queue, order preserved
    door = 1'b0;
    push(3'd1); push(3'd2); push(3'd3); push(3'd0);
    ifc.req_valid = 1'b1; ifc.req_prog = 3'd1;
    #1;
    chk("t3_full_ready", int'(ifc.req_ready), 0);
    step();
    ifc.req_valid = 1'b0;
    chk("t3_qcnt4", int'(qcnt), 4);
    chk("t3_hold_door", int'(hold), 1);
    chk("t3_nostart", int'(wstart), 0);
    door = 1'b1;
    dispatch("t3_j1", 1);
    dispatch("t3_j2", 2);
    dispatch("t3_j3", 3);
    dispatch("t3_j4", 0);
    chk("t3_jobs", int'(jobs), 5);

    // 4: soap gating on wash programs only
    soap = 1'b0;
    push(3'd0); push(3'd3);
    step(); step();
    chk("t4_hold_soap", int'(hold), 2);
    chk("t4_nostart", int'(wstart), 0);
    chk("t4_qcnt2", int'(qcnt), 2);
    soap = 1'b1;
    dispatch("t4_j0", 0);
    dispatch("t4_j3", 3);
    soap = 1'b0;
    push(3'd3);
    dispatch("t4_dry_nosoap", 3);
    soap = 1'b1;
    chk("t4_jobs", int'(jobs), 8);
    step();

    // 5: invalid code, then power loss mid-run
    ifc.req_valid = 1'b1; ifc.req_prog = 3'd5;
    step();
    ifc.req_valid = 1'b0;
    chk("t5_reject", int'(ifc.req_reject), 1);
    chk("t5_rej_qcnt", int'(qcnt), 0);
    step();
    chk("t5_reject_1cyc", int'(ifc.req_reject), 0);
    push(3'd2);
    n = 0;
    while (!wstart && n < 20) begin
      step();
      n++;
    end
    chk("t5_start", int'(wstart), 1);
    step();
    push(3'd1);
    chk("t5_run_busy", int'(busy), 1);
    chk("t5_qcnt1", int'(qcnt), 1);
    power = 1'b0;
    step();
    chk("t5_flush_qcnt", int'(qcnt), 0);
    chk("t5_flush_busy", int'(busy), 0);
    chk("t5_flush_jobs", int'(jobs), 8);
    chk("t5_flush_ready", int'(ifc.req_ready), 0);
    power = 1'b1;
    wdone = 1'b1;
    step();
    wdone = 1'b0;
    chk("t5_done_ignored", int'(jobs), 8);
    chk("t5_ready_back", int'(ifc.req_ready), 1);

    // 6: watchdog expiry on the 100-cycle instance
    rst_t = 1'b0;
    ifc_t.req_valid = 1'b1; ifc_t.req_prog = 3'd0;
    step();
    ifc_t.req_valid = 1'b0;
    step(); step();
    chk("t6_start", int'(wstart_t), 1);
    ifc_t.req_valid = 1'b1; ifc_t.req_prog = 3'd1;
    step();
    ifc_t.req_prog = 3'd2;
    step();
    ifc_t.req_valid = 1'b0;
    repeat (90) step();
    chk("t6_nofault_early", int'(fault_t), 0);
    chk("t6_still_busy", int'(busy_t), 1);
    repeat (15) step();
    chk("t6_fault", int'(fault_t), 1);
    chk("t6_ready0", int'(ifc_t.req_ready), 0);
    chk("t6_qcnt_kept", int'(qcnt_t), 2);
    n = 0;
    repeat (10) begin
      step();
      if (wstart_t) n++;
    end
    chk("t6_no_dispatch", n, 0);
    chk("t6_fault_sticky", int'(fault_t), 1);
    rst_t = 1'b1;
    step();
    chk("t6_rst_fault", int'(fault_t), 0);
    chk("t6_rst_qcnt", int'(qcnt_t), 0);
    rst_t = 1'b0;
    step(); step(); step();
    chk("t6_idle_after_rst", int'(wstart_t), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
